// File: rtl/core_run_sequencer.sv
// core_run_sequencer: host-side launch/collect controller for the 8-bit core.
// It holds the core in reset while idle. On `start` it pulses the core reset
// and then `core_req`. It counts RUN cycles until `core_done` or a timeout.
// It then sweeps a data-memory window through an asynchronous read port and
// reports an 8-bit modular checksum together with the cycle count.
//
// Ports:
//   clk          - single clock, rising edge
//   reset        - asynchronous, active-low
//   start        - host launch request, sampled only in IDLE
//   busy         - high in every state except IDLE
//   core_reset   - active-high reset to the core
//   core_req     - one-cycle run request to the core
//   core_done    - core completion, sampled only in RUN
//   mem_rd_addr  - data-memory read address (combinational)
//   mem_rd_data  - read data for mem_rd_addr, same cycle
//   result_valid - one-cycle strobe while in REPORT
//   checksum     - sum mod 256 of the swept bytes
//   cycles       - RUN cycles counted
//   timed_out    - run aborted without core_done
module core_run_sequencer #(
  parameter int unsigned RST_CYC   = 2,
  parameter int unsigned TIMEOUT   = 4096,
  parameter logic [7:0]  DUMP_BASE = 8'h00,
  parameter int unsigned DUMP_LEN  = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        busy,
  output logic        core_reset,
  output logic        core_req,
  input  logic        core_done,
  output logic [7:0]  mem_rd_addr,
  input  logic [7:0]  mem_rd_data,
  output logic        result_valid,
  output logic [7:0]  checksum,
  output logic [15:0] cycles,
  output logic        timed_out
);

  typedef enum logic [2:0] {
    IDLE,
    RESET_CORE,
    REQ,
    RUN,
    DUMP,
    REPORT
  } state_t;

  localparam logic [15:0] RST_LAST  = 16'(RST_CYC - 1);
  localparam logic [15:0] TIMEOUT_V = 16'(TIMEOUT);
  localparam logic [7:0]  DUMP_LAST = 8'(DUMP_LEN - 1);

  state_t      state, state_d;
  logic [15:0] rst_cnt, rst_cnt_d;
  logic [7:0]  idx, idx_d;
  logic [15:0] cycles_inc;
  logic        rst_last, dump_last, timeout_hit;

  logic        busy_d, core_reset_d, core_req_d, result_valid_d, timed_out_d;
  logic [7:0]  checksum_d;
  logic [15:0] cycles_d;

  assign cycles_inc  = cycles + 16'd1;
  assign rst_last    = (rst_cnt == RST_LAST);
  assign dump_last   = (idx == DUMP_LAST);
  assign timeout_hit = (cycles_inc == TIMEOUT_V);

  // Address wraps naturally at 8 bits; parked on the base outside DUMP.
  assign mem_rd_addr = (state == DUMP) ? 8'(DUMP_BASE + idx) : DUMP_BASE;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Next-state logic; a done in the timeout cycle still wins.
  always_comb begin
    state_d = state;
    case (state)
      IDLE:       if (start)     state_d = RESET_CORE;
      RESET_CORE: if (rst_last)  state_d = REQ;
      REQ:                       state_d = RUN;
      RUN: begin
        if (core_done)        state_d = DUMP;
        else if (timeout_hit) state_d = REPORT;
      end
      DUMP:       if (dump_last) state_d = REPORT;
      REPORT:                    state_d = IDLE;
      default:                   state_d = IDLE;
    endcase
  end

  // Output logic. Control outputs are decoded from the next state and then
  // registered, so each registered output lines up with the state it belongs to.
  always_comb begin
    busy_d         = (state_d != IDLE);
    core_reset_d   = !(state_d inside {REQ, RUN});
    core_req_d     = (state_d == REQ);
    result_valid_d = (state_d == REPORT);
    checksum_d     = checksum;
    cycles_d       = cycles;
    timed_out_d    = timed_out;
    idx_d          = idx;
    rst_cnt_d      = rst_cnt;
    case (state)
      IDLE: begin
        // Results are cleared on entry, so they read 0 throughout RESET_CORE.
        if (start) begin
          checksum_d  = '0;
          cycles_d    = '0;
          timed_out_d = 1'b0;
          idx_d       = '0;
          rst_cnt_d   = '0;
        end
      end
      RESET_CORE: rst_cnt_d = rst_cnt + 16'd1;
      RUN: begin
        cycles_d = cycles_inc;
        if (!core_done && timeout_hit) timed_out_d = 1'b1;
      end
      DUMP: begin
        checksum_d = checksum + mem_rd_data;
        idx_d      = idx + 8'd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy         <= 1'b0;
      core_reset   <= 1'b1;
      core_req     <= 1'b0;
      result_valid <= 1'b0;
      checksum     <= '0;
      cycles       <= '0;
      timed_out    <= 1'b0;
      idx          <= '0;
      rst_cnt      <= '0;
    end else begin
      busy         <= busy_d;
      core_reset   <= core_reset_d;
      core_req     <= core_req_d;
      result_valid <= result_valid_d;
      checksum     <= checksum_d;
      cycles       <= cycles_d;
      timed_out    <= timed_out_d;
      idx          <= idx_d;
      rst_cnt      <= rst_cnt_d;
    end
  end

endmodule

// File: tb/tb_core_run_sequencer.sv
// Bench for core_run_sequencer. Three instances share clock and reset:
//   0: defaults, 1: TIMEOUT=20, 2: DUMP_BASE=0xF0 / DUMP_LEN=32.
// Offsets are cycle numbers relative to the edge that samples start
// (offset 1 is the first RESET_CORE cycle); outputs are sampled on negedges.
module tb_core_run_sequencer;

  localparam int RST_C = 2;
  localparam int BASE [3] = '{0, 0, 'hF0};
  localparam int LEN  [3] = '{64, 64, 32};
  localparam int TOUT [3] = '{4096, 20, 4096};

  logic             clk = 1'b0;
  logic             rst;
  logic [2:0]       start_v, done_v, busy_v, creset_v, creq_v, rv_v, to_v;
  logic [2:0][7:0]  addr_v, data_v, csum_v;
  logic [2:0][15:0] cyc_v;
  logic [7:0]       mem [3][256];

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0]  csum;
    logic [15:0] cycles;
    logic        to;
    int          rv_off;
  } exp_t;

  typedef struct {
    int          rv_cnt;
    int          rv_off;
    logic [7:0]  csum;
    logic [15:0] cycles;
    logic        to;
    int          req_cnt;
    int          req_off;
    int          rst_hi;
    int          addr_err;
    logic        busy_after;
  } obs_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  core_run_sequencer u_def (
    .clk(clk), .reset(rst), .start(start_v[0]), .busy(busy_v[0]),
    .core_reset(creset_v[0]), .core_req(creq_v[0]), .core_done(done_v[0]),
    .mem_rd_addr(addr_v[0]), .mem_rd_data(data_v[0]), .result_valid(rv_v[0]),
    .checksum(csum_v[0]), .cycles(cyc_v[0]), .timed_out(to_v[0])
  );

  core_run_sequencer #(.TIMEOUT(20)) u_to (
    .clk(clk), .reset(rst), .start(start_v[1]), .busy(busy_v[1]),
    .core_reset(creset_v[1]), .core_req(creq_v[1]), .core_done(done_v[1]),
    .mem_rd_addr(addr_v[1]), .mem_rd_data(data_v[1]), .result_valid(rv_v[1]),
    .checksum(csum_v[1]), .cycles(cyc_v[1]), .timed_out(to_v[1])
  );

  core_run_sequencer #(.DUMP_BASE(8'hF0), .DUMP_LEN(32)) u_wrap (
    .clk(clk), .reset(rst), .start(start_v[2]), .busy(busy_v[2]),
    .core_reset(creset_v[2]), .core_req(creq_v[2]), .core_done(done_v[2]),
    .mem_rd_addr(addr_v[2]), .mem_rd_data(data_v[2]), .result_valid(rv_v[2]),
    .checksum(csum_v[2]), .cycles(cyc_v[2]), .timed_out(to_v[2])
  );

  assign data_v[0] = mem[0][addr_v[0]];
  assign data_v[1] = mem[1][addr_v[1]];
  assign data_v[2] = mem[2][addr_v[2]];

  // Launches one run on instance `inst` and records what it does.
  // done_at = RUN cycle on which core_done is driven (0 = never).
  task automatic drive_run(input int inst, input int done_at, input bit noise,
                           output obs_t o);
    int dump0, bound, rv_at;
    logic [7:0] ea;
    o = '{default: 0};
    dump0 = RST_C + 2 + done_at;
    bound = RST_C + TOUT[inst] + LEN[inst] + 40;
    rv_at = -1;
    @(negedge clk); start_v[inst] = 1'b1;
    @(negedge clk); start_v[inst] = 1'b0;
    for (int off = 1; off <= bound; off++) begin
      if (off > 1) @(negedge clk);
      if (creq_v[inst]) begin o.req_cnt++; o.req_off = off; end
      if (creset_v[inst] && busy_v[inst] && o.req_cnt == 0) o.rst_hi++;
      if (done_at > 0 && off >= dump0 && off < dump0 + LEN[inst])
        ea = 8'(BASE[inst] + off - dump0);
      else
        ea = 8'(BASE[inst]);
      if (addr_v[inst] !== ea) o.addr_err++;
      if (rv_v[inst]) begin
        o.rv_cnt++;
        if (rv_at < 0) begin
          rv_at    = off;
          o.rv_off = off;
          o.csum   = csum_v[inst];
          o.cycles = cyc_v[inst];
          o.to     = to_v[inst];
        end
      end
      if (rv_at >= 0 && off == rv_at + 1) o.busy_after = busy_v[inst];
      // Stimulus for the edge that ends this cycle.
      done_v[inst] = (done_at > 0 && off == RST_C + 1 + done_at);
      if (noise) begin
        if (off == RST_C + 1) done_v[inst] = 1'b1;
        if (done_at > 0 && off == dump0 + 3) done_v[inst] = 1'b1;
        start_v[inst] = (off == RST_C + 3) || (done_at > 0 && off == dump0 + 2);
      end
      if (rv_at >= 0 && off >= rv_at + 3) break;
    end
    done_v[inst]  = 1'b0;
    start_v[inst] = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (creset_v[i] !== 1'b1) begin
        errors++;
        $display("FAIL reset_core_reset[%0d]: got %b want 1", i, creset_v[i]);
      end
      checks++;
      if ({busy_v[i], creq_v[i], rv_v[i], to_v[i]} !== 4'b0000) begin
        errors++;
        $display("FAIL reset_flags[%0d]: got busy/req/rv/to=%b%b%b%b want 0000",
                 i, busy_v[i], creq_v[i], rv_v[i], to_v[i]);
      end
      checks++;
      if ({csum_v[i], cyc_v[i]} !== 24'h0) begin
        errors++;
        $display("FAIL reset_results[%0d]: got csum=%h cycles=%0d want 00/0",
                 i, csum_v[i], cyc_v[i]);
      end
      checks++;
      if (addr_v[i] !== 8'(BASE[i])) begin
        errors++;
        $display("FAIL reset_addr[%0d]: got %h want %h", i, addr_v[i], 8'(BASE[i]));
      end
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    obs_t o; exp_t e;
    sb.push_back('{csum: 8'hE0, cycles: 16'd10, to: 1'b0, rv_off: RST_C + 2 + 10 + 64});
    drive_run(0, 10, 1'b0, o);
    e = sb.pop_front();
    checks++;
    if ({o.csum, o.cycles, o.to} !== {e.csum, e.cycles, e.to}) begin
      errors++;
      $display("FAIL basic_result: got csum=%h cycles=%0d to=%b want csum=%h cycles=%0d to=%b",
               o.csum, o.cycles, o.to, e.csum, e.cycles, e.to);
    end
    checks++;
    if (o.rv_cnt != 1 || o.rv_off != e.rv_off) begin
      errors++;
      $display("FAIL basic_valid: got %0d strobes at offset %0d want 1 at %0d",
               o.rv_cnt, o.rv_off, e.rv_off);
    end
    checks++;
    if (o.rst_hi != RST_C || o.req_cnt != 1 || o.req_off != RST_C + 1) begin
      errors++;
      $display("FAIL basic_handshake: got rst_hi=%0d req=%0d@%0d want %0d, 1@%0d",
               o.rst_hi, o.req_cnt, o.req_off, RST_C, RST_C + 1);
    end
    checks++;
    if (o.addr_err != 0) begin
      errors++;
      $display("FAIL basic_addr: got %0d bad address cycles want 0", o.addr_err);
    end
    checks++;
    if (o.busy_after !== 1'b0) begin
      errors++;
      $display("FAIL basic_busy_fall: got busy=%b after REPORT want 0", o.busy_after);
    end
  endtask

  task automatic test_timeout();
    obs_t o; exp_t e;
    sb.push_back('{csum: 8'h00, cycles: 16'd20, to: 1'b1, rv_off: RST_C + 2 + 20});
    drive_run(1, 0, 1'b0, o);
    e = sb.pop_front();
    checks++;
    if ({o.csum, o.cycles, o.to} !== {e.csum, e.cycles, e.to}) begin
      errors++;
      $display("FAIL timeout_result: got csum=%h cycles=%0d to=%b want csum=%h cycles=%0d to=%b",
               o.csum, o.cycles, o.to, e.csum, e.cycles, e.to);
    end
    checks++;
    if (o.rv_cnt != 1 || o.rv_off != e.rv_off) begin
      errors++;
      $display("FAIL timeout_valid: got %0d strobes at offset %0d want 1 at %0d",
               o.rv_cnt, o.rv_off, e.rv_off);
    end
    checks++;
    if (o.addr_err != 0) begin
      errors++;
      $display("FAIL timeout_no_dump: got %0d off-base address cycles want 0", o.addr_err);
    end
  endtask

  task automatic test_timeout_tie();
    obs_t o; exp_t e;
    sb.push_back('{csum: 8'hE0, cycles: 16'd20, to: 1'b0, rv_off: RST_C + 2 + 20 + 64});
    drive_run(1, 20, 1'b0, o);
    e = sb.pop_front();
    checks++;
    if ({o.csum, o.cycles, o.to} !== {e.csum, e.cycles, e.to}) begin
      errors++;
      $display("FAIL tie_result: got csum=%h cycles=%0d to=%b want csum=%h cycles=%0d to=%b",
               o.csum, o.cycles, o.to, e.csum, e.cycles, e.to);
    end
    checks++;
    if (o.rv_cnt != 1 || o.rv_off != e.rv_off || o.addr_err != 0) begin
      errors++;
      $display("FAIL tie_dump: got %0d strobes at %0d, %0d bad addr want 1 at %0d, 0",
               o.rv_cnt, o.rv_off, o.addr_err, e.rv_off);
    end
  endtask

  task automatic test_wrap();
    obs_t o; exp_t e;
    sb.push_back('{csum: 8'h20, cycles: 16'd5, to: 1'b0, rv_off: RST_C + 2 + 5 + 32});
    drive_run(2, 5, 1'b0, o);
    e = sb.pop_front();
    checks++;
    if ({o.csum, o.cycles, o.to} !== {e.csum, e.cycles, e.to}) begin
      errors++;
      $display("FAIL wrap_result: got csum=%h cycles=%0d to=%b want csum=%h cycles=%0d to=%b",
               o.csum, o.cycles, o.to, e.csum, e.cycles, e.to);
    end
    checks++;
    if (o.addr_err != 0) begin
      errors++;
      $display("FAIL wrap_addr: got %0d bad address cycles want 0", o.addr_err);
    end
    checks++;
    if (o.rv_cnt != 1 || o.rv_off != e.rv_off) begin
      errors++;
      $display("FAIL wrap_valid: got %0d strobes at offset %0d want 1 at %0d",
               o.rv_cnt, o.rv_off, e.rv_off);
    end
  endtask

  task automatic test_ignored_inputs();
    obs_t o; exp_t e;
    sb.push_back('{csum: 8'hE0, cycles: 16'd10, to: 1'b0, rv_off: RST_C + 2 + 10 + 64});
    drive_run(0, 10, 1'b1, o);
    e = sb.pop_front();
    checks++;
    if ({o.csum, o.cycles, o.to} !== {e.csum, e.cycles, e.to}) begin
      errors++;
      $display("FAIL noise_result: got csum=%h cycles=%0d to=%b want csum=%h cycles=%0d to=%b",
               o.csum, o.cycles, o.to, e.csum, e.cycles, e.to);
    end
    checks++;
    if (o.rv_cnt != 1 || o.rv_off != e.rv_off || o.req_cnt != 1) begin
      errors++;
      $display("FAIL noise_single: got %0d strobes at %0d, %0d reqs want 1 at %0d, 1",
               o.rv_cnt, o.rv_off, o.req_cnt, e.rv_off);
    end
    checks++;
    if (o.busy_after !== 1'b0) begin
      errors++;
      $display("FAIL noise_requeue: got busy=%b after REPORT want 0", o.busy_after);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int rv_seen = 0;
    sb.push_back('{csum: 8'h20, cycles: 16'd3, to: 1'b0, rv_off: 39});
    sb.push_back('{csum: 8'h20, cycles: 16'd3, to: 1'b0, rv_off: 79});
    @(negedge clk); start_v[2] = 1'b1;
    @(negedge clk);
    for (int off = 1; off <= 100; off++) begin
      if (off > 1) @(negedge clk);
      if (rv_v[2]) begin
        rv_seen++;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL b2b_extra: got result_valid at offset %0d want none", off);
        end else begin
          e = sb.pop_front();
          if ({csum_v[2], cyc_v[2], to_v[2]} !== {e.csum, e.cycles, e.to} || off != e.rv_off) begin
            errors++;
            $display("FAIL b2b_result: got csum=%h cycles=%0d to=%b at %0d want csum=%h cycles=%0d to=%b at %0d",
                     csum_v[2], cyc_v[2], to_v[2], off, e.csum, e.cycles, e.to, e.rv_off);
          end
        end
      end
      done_v[2] = (off == 6) || (off == 46);
      if (off == 79) start_v[2] = 1'b0;
    end
    done_v[2] = 1'b0;
    checks++;
    if (sb.size() != 0 || rv_seen != 2) begin
      errors++;
      $display("FAIL b2b_count: got %0d strobes, %0d pending want 2, 0", rv_seen, sb.size());
      sb.delete();
    end
    checks++;
    if (busy_v[2] !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle: got busy=%b want 0", busy_v[2]);
    end
  endtask

  task automatic test_reset_mid_dump();
    obs_t o; exp_t e;
    int rv_cnt = 0;
    @(negedge clk); start_v[0] = 1'b1;
    @(negedge clk); start_v[0] = 1'b0;
    for (int off = 1; off <= RST_C + 2 + 5 + 10; off++) begin
      if (off > 1) @(negedge clk);
      done_v[0] = (off == RST_C + 1 + 5);
    end
    done_v[0] = 1'b0;
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({creset_v[0], busy_v[0], rv_v[0], creq_v[0]} !== 4'b1000) begin
      errors++;
      $display("FAIL async_ctrl: got reset/busy/rv/req=%b%b%b%b want 1000",
               creset_v[0], busy_v[0], rv_v[0], creq_v[0]);
    end
    checks++;
    if ({csum_v[0], cyc_v[0], addr_v[0]} !== 32'h0) begin
      errors++;
      $display("FAIL async_results: got csum=%h cycles=%0d addr=%h want 00/0/00",
               csum_v[0], cyc_v[0], addr_v[0]);
    end
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (rv_v[0]) rv_cnt++;
    end
    checks++;
    if (rv_cnt != 0 || busy_v[0] !== 1'b0) begin
      errors++;
      $display("FAIL async_no_valid: got %0d strobes busy=%b want 0, 0", rv_cnt, busy_v[0]);
    end
    sb.push_back('{csum: 8'hE0, cycles: 16'd10, to: 1'b0, rv_off: RST_C + 2 + 10 + 64});
    drive_run(0, 10, 1'b0, o);
    e = sb.pop_front();
    checks++;
    if ({o.csum, o.cycles, o.to} !== {e.csum, e.cycles, e.to} || o.rv_off != e.rv_off) begin
      errors++;
      $display("FAIL async_rerun: got csum=%h cycles=%0d to=%b at %0d want csum=%h cycles=%0d to=%b at %0d",
               o.csum, o.cycles, o.to, o.rv_off, e.csum, e.cycles, e.to, e.rv_off);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got time limit reached want normal completion");
    $fatal(1, "watchdog");
  end

  initial begin
    start_v = '0;
    done_v  = '0;
    rst     = 1'b0;
    for (int a = 0; a < 256; a++) begin
      mem[0][a] = (a < 64) ? 8'(a) : 8'hA5;
      mem[1][a] = (a < 64) ? 8'(a) : 8'h5A;
      mem[2][a] = 8'h01;
    end
    test_reset();
    test_basic();
    test_timeout();
    test_timeout_tie();
    test_wrap();
    test_ignored_inputs();
    test_back_to_back();
    test_reset_mid_dump();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
